ook_tx_ctrl: RTL

//   Frame sequencer for the OOK transmitter. Accepts bytes over a valid/ready

---
 rtl/ook_pkg.sv | 22 ++
 rtl/ook_tx_ctrl_if.sv | 11 +
 rtl/ook_baud_gen.sv | 44 ++++
 rtl/ook_tx_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ook_pkg.sv
// Shared types and constants for the OOK transmit frame sequencer.
package ook_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_STOP     = 3'd4
  } state_e;

  localparam int unsigned DATA_BITS = 8;

  // 2 MHz carrier tuning word
  localparam logic [28:0] FTW_DEFAULT = 29'd21_474_836;

  // Bits needed to count 0..n-1 (never less than 1)
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ook_tx_ctrl_if.sv
// Byte-stream valid/ready handshake into the OOK frame sequencer.
interface ook_tx_ctrl_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ook_baud_gen.sv
// Modulo-BAUD_DIV bit timer; tick is high on the last clk of each bit period.
module ook_baud_gen
  import ook_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = cnt_w(BAUD_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count; tick registered alongside so it lines up with cnt==BAUD_DIV-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(BAUD_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == CW'(BAUD_DIV - 1));
  end

  // Counter and tick registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ook_tx_ctrl.sv
// OOK frame sequencer: preamble, start, 8 data bits MSB-first, stop; drives DDS gate.
module ook_tx_ctrl
  import ook_pkg::*;
#(
  parameter int unsigned            BAUD_DIV      = 5000,
  parameter int unsigned            PREAMBLE_BITS = 8,
  parameter int unsigned            FTW_W         = 29,
  parameter logic [FTW_W-1:0]       FTW           = FTW_W'(FTW_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  ook_tx_ctrl_if.slave     s_if,
  output logic             carrier_en,
  output logic [FTW_W-1:0] dds_ftw,
  output logic             dds_phase_clr,
  output logic             bit_tick,
  output logic             busy,
  output logic             tx_done
);

  localparam int unsigned IDX_MAX = (PREAMBLE_BITS > DATA_BITS) ? PREAMBLE_BITS : DATA_BITS;
  localparam int unsigned IW      = cnt_w(IDX_MAX);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 carrier_q, carrier_d;
  logic                 phase_clr_q, phase_clr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 accept;

  // Bit timer is parked at zero while idle so the first bit is full length
  ook_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  // Ready when idle, or on the stop tick to chain the next byte without a gap
  assign s_if.s_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_STOP && tick));
  assign accept       = s_if.s_valid && s_if.s_ready;

  // Next state, shift register, bit index and registered outputs
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    phase_clr_d = 1'b0;
    done_d      = 1'b0;
    carrier_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_PREAMBLE;
          idx_d       = '0;
          shreg_d     = s_if.s_data;
          phase_clr_d = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (tick) begin
          if (idx_q == IW'(PREAMBLE_BITS - 1)) begin
            state_d = ST_START;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d = shreg_q << 1;
          if (idx_q == IW'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (accept) begin
            state_d = ST_START;
            shreg_d = s_if.s_data;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Carrier follows the state being entered so it changes on the first clk of each bit
    case (state_d)
      ST_PREAMBLE: carrier_d = ~idx_d[0];
      ST_START:    carrier_d = 1'b1;
      ST_DATA:     carrier_d = shreg_d[DATA_BITS-1];
      default:     carrier_d = 1'b0;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      carrier_q   <= 1'b0;
      phase_clr_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      carrier_q   <= carrier_d;
      phase_clr_q <= phase_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign carrier_en    = carrier_q;
  assign dds_ftw       = FTW;
  assign dds_phase_clr = phase_clr_q;
  assign bit_tick      = tick;
  assign busy          = busy_q;
  assign tx_done       = done_q;

endmodule
